// File: rtl/val_capture_pkg.sv
// Shared constants and types for the val counter capture path.
package val_capture_pkg;

    // Width of the upstream free-running val counter.
    localparam int VAL_W  = 12;

    // Width of the saturating drop counter reported to the C side.
    localparam int DROP_W = 16;

    // One buffered sample: the counter value plus its wrap-around tag.
    typedef struct packed {
        logic             wrap;
        logic [VAL_W-1:0] data;
    } val_sample_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. Occupancy is tracked in a level
// register so full/empty never depend on pointer equality.
module sync_fifo_fwft #(
    parameter int W     = 13,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        empty   = (level_q == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem_q[rd_ptr_q];
        level   = level_q;

        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy state; reset empties the FIFO outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sample storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/val_capture_fifo.sv
// Captures the val counter on a strobe, decimates, tags wrap-around, buffers
// the samples for a valid/ready sink and counts samples lost to a full FIFO.
module val_capture_fifo
    import val_capture_pkg::*;
#(
    parameter int WIDTH = VAL_W,
    parameter int DEPTH = 8,
    parameter int DECIM = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_val,
    input  logic                   in_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_wrap,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int                DCNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);

    logic [DCNT_W-1:0] decim_cnt_q, decim_cnt_d;
    logic [WIDTH-1:0]  prev_val_q, prev_val_d;
    logic              prev_ok_q, prev_ok_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [WIDTH-1:0]  hold_data_q, hold_data_d;
    logic              hold_wrap_q, hold_wrap_d;

    logic              capture;
    logic              wrap;
    logic              pop;
    logic              push;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WIDTH:0]    fifo_wdata;
    logic [WIDTH:0]    fifo_rdata;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

    // Decimation, wrap tagging, push/drop decision and the output hold value.
    always_comb begin
        capture    = in_en && (decim_cnt_q == DCNT_LAST);
        wrap       = prev_ok_q && (in_val < prev_val_q);
        pop        = !fifo_empty && out_ready;
        push       = capture && (!fifo_full || pop);
        drop       = capture && !push;
        fifo_wdata = {wrap, in_val};

        decim_cnt_d = decim_cnt_q;
        if (in_en) begin
            decim_cnt_d = capture ? '0 : decim_cnt_q + DCNT_W'(1);
        end

        // Dropped captures still advance the wrap reference.
        prev_val_d = capture ? in_val : prev_val_q;
        prev_ok_d  = prev_ok_q || capture;

        drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;

        // Remember the entry leaving the FIFO so the outputs hold it once empty.
        hold_data_d = pop ? fifo_rdata[WIDTH-1:0] : hold_data_q;
        hold_wrap_d = pop ? fifo_rdata[WIDTH]     : hold_wrap_q;

        out_valid = !fifo_empty;
        out_data  = fifo_empty ? hold_data_q : fifo_rdata[WIDTH-1:0];
        out_wrap  = fifo_empty ? hold_wrap_q : fifo_rdata[WIDTH];
        full      = fifo_full;
        drop_cnt  = drop_cnt_q;
    end

    // Control state cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            decim_cnt_q <= '0;
            prev_ok_q   <= 1'b0;
            drop_cnt_q  <= '0;
            hold_data_q <= '0;
            hold_wrap_q <= 1'b0;
        end else begin
            decim_cnt_q <= decim_cnt_d;
            prev_ok_q   <= prev_ok_d;
            drop_cnt_q  <= drop_cnt_d;
            hold_data_q <= hold_data_d;
            hold_wrap_q <= hold_wrap_d;
        end
    end

    // Previous captured value; only meaningful while prev_ok_q is set.
    always_ff @(posedge clk) begin
        prev_val_q <= prev_val_d;
    end

    sync_fifo_fwft #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: doc/val_capture_fifo.md
# val_capture_fifo

Capture stage directly downstream of the 12-bit free-running `val` counter in the VPI test bench. It samples the counter on a strobe, optionally decimates, tags each sample with a wrap-around flag, and buffers it in a small FIFO. The buffered samples drain over a valid/ready handshake to the VPI reporting sink. The block also counts dropped samples so the C side can check that no counter value was lost.

## Interface
Parameters:
- `WIDTH`, 12: sample width; it matches the counter width.
- `DEPTH`, 8: FIFO entries; must be a power of two and at least 2.
- `DECIM`, 1: capture one sample per `DECIM` strobes; must be at least 1.

Ports:
- `clk  in  1`: the only clock; all logic is on the rising edge.
- `rst  in  1`: **synchronous, active-high** reset.
- `in_val  in  WIDTH`: counter value from the upstream stage.
- `in_en  in  1`: sample strobe; one capture opportunity per cycle in which it is high.
- `out_valid  out  1`: the head entry is available.
- `out_ready  in  1`: the sink accepts the head entry.
- `out_data  out  WIDTH`: sample at the head.
- `out_wrap  out  1`: the head sample is numerically lower than the previously captured sample.
- `level  out  $clog2(DEPTH)+1`: current occupancy.
- `full  out  1`: `level == DEPTH`.
- `drop_cnt  out  16`: count of samples dropped because the FIFO was full; saturates at `16'hFFFF`.

## Operation
Decimation:
- A `decim_cnt` register counts strobes from 0 to `DECIM-1`.
- A capture occurs on any strobe for which `decim_cnt == DECIM-1`; `decim_cnt` then returns to 0. With `DECIM=1`, every strobe captures.
- `decim_cnt` advances only on cycles where `in_en` is high.

Wrap tagging:
- `prev_val` and `prev_ok` update on every capture, including captures that are dropped.
- `wrap = prev_ok && (in_val < prev_val)`, using an unsigned `WIDTH`-bit comparison.
- The first capture after reset always has `wrap = 0`.

Push:
- A capture pushes `{wrap, in_val}` if `!full`, or if the FIFO is full and a pop occurs in the same cycle.
- Otherwise the sample is dropped and `drop_cnt` increments (saturating).

Pop:
- A pop occurs when `out_valid && out_ready`.
- The FIFO is first-word-fall-through: `out_data` and `out_wrap` always show the head entry while `out_valid` is high.
- While `out_valid` is low, `out_data` and `out_wrap` hold their last value (0 after reset).

Level:
- Unchanged on a simultaneous push and pop.
- +1 on a push alone, −1 on a pop alone.

Protocol:
- The sink may hold `out_ready` low indefinitely.
- Once `out_valid` is asserted, the head entry is stable until it is popped.

## Timing
- Capture latency: a sample captured on edge N gives `out_valid` = 1 after edge N, provided the FIFO was empty; that is one cycle from strobe to visibility.
- A pop at edge N presents the next entry after edge N; back-to-back pops sustain 1 entry per cycle.
- Reset: when `rst` is high at an edge, the following are cleared:
  - `out_valid`=0, `out_data`=0, `out_wrap`=0
  - `level`=0, `full`=0, `drop_cnt`=0
  - `decim_cnt`=0, `prev_ok`=0
- Reset takes priority over any concurrent push or pop. If reset arrives mid-stream, buffered entries are discarded and no drop is counted for them.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Full and empty are derived from `level`, not from pointer equality.
- Counter wrap (`in_val` going from `12'hFFF` to `12'h000`) is a normal capture tagged `wrap=1`.

## Structure
- Package `val_capture_pkg` contains:
  - `localparam VAL_W = 12`
  - typedef `val_sample_t`, a packed struct `{logic wrap; logic [VAL_W-1:0] data;}`
  - `DROP_W = 16`
- Sub-module `sync_fifo_fwft` is parameterised by width and depth. It provides `push`/`pop`/`full`/`empty`/`level` and contains the storage and pointers.
- The top level contains the decimation counter, wrap tagging, drop counter and handshake glue.

## Test plan
- Reset, then one strobe with `in_val=5`: `out_valid`=1 after 1 edge, `out_data`=5, `out_wrap`=0, `level`=1.
- 8 strobes with values 10..17 and `out_ready`=0, then a 9th with 18: `full`=1, `drop_cnt`=1. Raising `out_ready` then drains 10..17 in order, one per cycle.
- Strobes with 0xFFE, 0xFFF, 0x000, 0x001: the wrap flags read out are 0, 0, 1, 0.
- `DECIM=3`, strobes with 1..9: the captured samples are 3, 6 and 9.
- Full FIFO with `out_ready`=1 and a strobe in the same cycle: the push is accepted, `level` stays 8 and `drop_cnt` is unchanged.
- `rst` asserted while `level`=5: after 1 edge, `level`=0, `out_valid`=0 and `drop_cnt`=0. The next capture of 0 gives `out_wrap`=0.
